// File: rtl/uart_avl_bridge.sv
// UART byte-command to Avalon-MM initiator: 'W'+addr+data / 'R'+addr frames, replies 'K', data, 'E' or '?'.
// Optional waitrequest watchdog (reply 'T') is enabled by defining UART_AVL_BRIDGE_TIMEOUT_EN.
module uart_avl_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_tdata,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    output logic [7:0]            tx_tdata,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    output logic [ADDR_WIDTH-1:0] avl_address,
    output logic                  avl_read,
    input  logic [31:0]           avl_readdata,
    input  logic [1:0]            avl_response,
    output logic                  avl_write,
    output logic [31:0]           avl_writedata,
    output logic [3:0]            avl_byteenable,
    input  logic                  avl_waitrequest,
    output logic                  busy
);
    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] RPL_OK   = 8'h4B;
    localparam logic [7:0] RPL_ERR  = 8'h45;
    localparam logic [7:0] RPL_BAD  = 8'h3F;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WR, BUS_RD, RESP} state_t;

    state_t                  state;
    logic [1:0]              cnt;
    logic                    is_wr;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             data_q;
    logic [31:0]             reply_q;
    logic [1:0]              left;

`ifdef UART_AVL_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] RPL_TMO = 8'h54;
    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         tmo;
`endif

    logic rx_fire;
    logic tx_fire;
    assign rx_fire       = rx_tvalid && rx_tready;
    assign tx_fire       = tx_tvalid && tx_tready;
    assign avl_address   = addr_q;
    assign avl_writedata = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            is_wr          <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            reply_q        <= '0;
            left           <= '0;
            rx_tready      <= 1'b0;
            tx_tvalid      <= 1'b0;
            tx_tdata       <= '0;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_byteenable <= '0;
            busy           <= 1'b0;
`ifdef UART_AVL_BRIDGE_TIMEOUT_EN
            tmo            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rx_tready <= 1'b1;
                    if (rx_fire) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        if (rx_tdata == CMD_WR || rx_tdata == CMD_RD) begin
                            is_wr  <= (rx_tdata == CMD_WR);
                            addr_q <= '0;
                            state  <= ADDR;
                        end else begin
                            rx_tready <= 1'b0;
                            tx_tvalid <= 1'b1;
                            tx_tdata  <= RPL_BAD;
                            left      <= '0;
                            state     <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        // Only the low ADDR_WIDTH bits of the 32-bit address survive the shift.
                        addr_q <= ADDR_WIDTH'({addr_q, rx_tdata});
                        cnt    <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (is_wr) begin
                                state <= DATA;
                            end else begin
                                rx_tready      <= 1'b0;
                                avl_read       <= 1'b1;
                                avl_byteenable <= 4'hF;
                                state          <= BUS_RD;
`ifdef UART_AVL_BRIDGE_TIMEOUT_EN
                                tmo            <= '0;
`endif
                            end
                        end
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        data_q <= {data_q[23:0], rx_tdata};
                        cnt    <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            rx_tready      <= 1'b0;
                            avl_write      <= 1'b1;
                            avl_byteenable <= 4'hF;
                            state          <= BUS_WR;
`ifdef UART_AVL_BRIDGE_TIMEOUT_EN
                            tmo            <= '0;
`endif
                        end
                    end
                end
                BUS_WR: begin
                    if (!avl_waitrequest) begin
                        avl_write      <= 1'b0;
                        avl_byteenable <= '0;
                        tx_tvalid      <= 1'b1;
                        tx_tdata       <= RPL_OK;
                        left           <= '0;
                        state          <= RESP;
                    end
`ifdef UART_AVL_BRIDGE_TIMEOUT_EN
                    else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        avl_write      <= 1'b0;
                        avl_byteenable <= '0;
                        tx_tvalid      <= 1'b1;
                        tx_tdata       <= RPL_TMO;
                        left           <= '0;
                        state          <= RESP;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
`endif
                end
                BUS_RD: begin
                    if (!avl_waitrequest) begin
                        avl_read       <= 1'b0;
                        avl_byteenable <= '0;
                        tx_tvalid      <= 1'b1;
                        state          <= RESP;
                        if (avl_response == 2'b00) begin
                            tx_tdata <= avl_readdata[31:24];
                            reply_q  <= avl_readdata;
                            left     <= 2'd3;
                        end else begin
                            tx_tdata <= RPL_ERR;
                            left     <= '0;
                        end
                    end
`ifdef UART_AVL_BRIDGE_TIMEOUT_EN
                    else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        avl_read       <= 1'b0;
                        avl_byteenable <= '0;
                        tx_tvalid      <= 1'b1;
                        tx_tdata       <= RPL_TMO;
                        left           <= '0;
                        state          <= RESP;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
`endif
                end
                RESP: begin
                    if (tx_fire) begin
                        if (left == 2'd0) begin
                            tx_tvalid <= 1'b0;
                            tx_tdata  <= '0;
                            rx_tready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            tx_tdata <= reply_q[23:16];
                            reply_q  <= {reply_q[23:0], 8'h00};
                            left     <= left - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_avl_bridge.sv
// Directed bench for uart_avl_bridge: frames in on RX, a small Avalon slave responder, replies checked on TX.
module tb_uart_avl_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [7:0]  avl_address;
    logic        avl_read;
    logic [31:0] avl_readdata;
    logic [1:0]  avl_response;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_avl_bridge #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst(rst),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .avl_address(avl_address), .avl_read(avl_read), .avl_readdata(avl_readdata),
        .avl_response(avl_response), .avl_write(avl_write), .avl_writedata(avl_writedata),
        .avl_byteenable(avl_byteenable), .avl_waitrequest(avl_waitrequest), .busy(busy)
    );

    // Called at a falling edge; returns at the falling edge after the last byte is taken.
    task automatic send_frame(input logic [71:0] bytes, input int n, output bit ok);
        int w;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            rx_tdata  = bytes[8*(n-1-i) +: 8];
            rx_tvalid = 1'b1;
            while (rx_tready !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (rx_tready !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        rx_tvalid = 1'b0;
    endtask

    task automatic recv(output logic [7:0] b, output bit ok);
        int w;
        w = 0;
        tx_tready = 1'b1;
        while (tx_tvalid !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        ok = (tx_tvalid === 1'b1);
        b  = tx_tdata;
        @(negedge clk);
    endtask

    task automatic recv_word(input int n, output logic [31:0] word, output bit ok);
        logic [7:0] b;
        bit         k;
        word = '0;
        ok   = 1'b1;
        for (int i = 0; i < n; i++) begin
            recv(b, k);
            word = {word[23:0], b};
            ok   = ok & k;
        end
    endtask

    // Avalon slave: stalls 'stall' cycles then completes; records what the master presented.
    task automatic serve_bus(input int stall, input logic [31:0] rdata, input logic [1:0] rsp,
                             output int cycles, output logic [7:0] addr, output logic [31:0] wdata,
                             output logic wr, output logic clash, output logic be_bad,
                             output logic unstable);
        cycles = 0; addr = '0; wdata = '0; wr = 1'b0; clash = 1'b0; be_bad = 1'b0; unstable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!(avl_read || avl_write)) break;
            cycles++;
            if (cycles > 1 && (addr !== avl_address || wdata !== avl_writedata)) unstable = 1'b1;
            addr  = avl_address;
            wdata = avl_writedata;
            wr    = avl_write;
            if (avl_read && avl_write) clash = 1'b1;
            if (avl_byteenable !== 4'hF) be_bad = 1'b1;
            if (cycles > stall) begin
                avl_waitrequest = 1'b0;
                avl_readdata    = rdata;
                avl_response    = rsp;
            end else begin
                avl_waitrequest = 1'b1;
            end
            @(negedge clk);
        end
        avl_waitrequest = 1'b0;
        avl_readdata    = '0;
        avl_response    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_tdata = '0; rx_tvalid = 1'b0; tx_tready = 1'b0;
        avl_readdata = '0; avl_response = '0; avl_waitrequest = 1'b0;
        #1 rst = 1'b1;
        #2;
        total++;
        if ({rx_tready, tx_tvalid, tx_tdata, avl_read, avl_write, avl_address, avl_writedata,
             avl_byteenable, busy} !== 57'd0) begin
            bad++; $display("FAIL reset_outputs: got rx_rdy=%b tx_vld=%b avl_rd=%b avl_wr=%b be=%h busy=%b want all zero",
                            rx_tready, tx_tvalid, avl_read, avl_write, avl_byteenable, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rx_tready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got rx_tready=%b busy=%b want 1 0", rx_tready, busy);
        end
    endtask

    task automatic test_write();
        bit ok; int cyc; logic [7:0] a, b; logic [31:0] wd; logic wr, clash, be_bad, unst;
        send_frame(72'h57_00000010_DEADBEEF, 9, ok);
        total++;
        if (ok !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL wr_frame: got accepted=%b busy=%b want 1 1", ok, busy);
        end
        serve_bus(0, 32'h0, 2'b00, cyc, a, wd, wr, clash, be_bad, unst);
        total++;
        if (cyc !== 1 || wr !== 1'b1 || clash !== 1'b0 || be_bad !== 1'b0) begin
            bad++; $display("FAIL wr_pulse: got cycles=%0d write=%b clash=%b be_bad=%b want 1 1 0 0", cyc, wr, clash, be_bad);
        end
        total++;
        if (a !== 8'h10 || wd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_addr_data: got %h/%h want 10/deadbeef", a, wd);
        end
        recv(b, ok);
        total++;
        if (ok !== 1'b1 || b !== 8'h4B || busy !== 1'b0) begin
            bad++; $display("FAIL wr_reply: got ok=%b byte=%h busy=%b want 1 4b 0", ok, b, busy);
        end
    endtask

    task automatic test_read();
        bit ok; int cyc; logic [7:0] a; logic [31:0] wd, word; logic wr, clash, be_bad, unst;
        send_frame(72'h52_00000004, 5, ok);
        total++;
        if (ok !== 1'b1 || avl_read !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rd_frame: got accepted=%b avl_read=%b busy=%b want 1 1 1", ok, avl_read, busy);
        end
        serve_bus(3, 32'h12345678, 2'b00, cyc, a, wd, wr, clash, be_bad, unst);
        total++;
        if (cyc !== 4 || wr !== 1'b0 || clash !== 1'b0 || be_bad !== 1'b0 || unst !== 1'b0) begin
            bad++; $display("FAIL rd_hold: got cycles=%0d write=%b clash=%b be_bad=%b unstable=%b want 4 0 0 0 0",
                            cyc, wr, clash, be_bad, unst);
        end
        total++;
        if (a !== 8'h04) begin
            bad++; $display("FAIL rd_addr: got %h want 04", a);
        end
        recv_word(4, word, ok);
        total++;
        if (ok !== 1'b1 || word !== 32'h12345678 || tx_tvalid !== 1'b0) begin
            bad++; $display("FAIL rd_reply: got ok=%b data=%h tx_tvalid=%b want 1 12345678 0", ok, word, tx_tvalid);
        end
    endtask

    task automatic test_read_err();
        bit ok; int cyc; logic [7:0] a, b; logic [31:0] wd; logic wr, clash, be_bad, unst;
        send_frame(72'h52_00000020, 5, ok);
        serve_bus(1, 32'hFFFFFFFF, 2'b10, cyc, a, wd, wr, clash, be_bad, unst);
        total++;
        if (ok !== 1'b1 || cyc !== 2 || a !== 8'h20) begin
            bad++; $display("FAIL rderr_bus: got ok=%b cycles=%0d addr=%h want 1 2 20", ok, cyc, a);
        end
        recv(b, ok);
        total++;
        if (ok !== 1'b1 || b !== 8'h45 || tx_tvalid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rderr_reply: got ok=%b byte=%h tx_tvalid=%b busy=%b want 1 45 0 0",
                            ok, b, tx_tvalid, busy);
        end
    endtask

    task automatic test_bad_cmd();
        bit ok; int cyc; logic [7:0] a; logic [31:0] wd, word; logic wr, clash, be_bad, unst;
        tx_tready = 1'b0;
        rx_tdata  = 8'h41;
        rx_tvalid = 1'b1;
        total++;
        if (rx_tready !== 1'b1) begin
            bad++; $display("FAIL bad_idle_ready: got %b want 1", rx_tready);
        end
        @(negedge clk);
        rx_tdata = 8'h52;
        total++;
        if (rx_tready !== 1'b0 || tx_tvalid !== 1'b1 || tx_tdata !== 8'h3F || avl_read !== 1'b0 || avl_write !== 1'b0) begin
            bad++; $display("FAIL bad_reply: got rx_rdy=%b tx_vld=%b tx=%h rd=%b wr=%b want 0 1 3f 0 0",
                            rx_tready, tx_tvalid, tx_tdata, avl_read, avl_write);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rx_tready !== 1'b0 || tx_tdata !== 8'h3F || avl_read !== 1'b0 || avl_write !== 1'b0) begin
                bad++; $display("FAIL resp_rx_held: got rx_rdy=%b tx=%h rd=%b wr=%b want 0 3f 0 0",
                                rx_tready, tx_tdata, avl_read, avl_write);
            end
        end
        tx_tready = 1'b1;
        @(negedge clk);
        total++;
        if (tx_tvalid !== 1'b0 || rx_tready !== 1'b1) begin
            bad++; $display("FAIL bad_done: got tx_tvalid=%b rx_tready=%b want 0 1", tx_tvalid, rx_tready);
        end
        @(negedge clk);
        rx_tvalid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL held_byte_taken: got busy=%b want 1", busy);
        end
        send_frame(72'h00000008, 4, ok);
        serve_bus(0, 32'hA5A55A5A, 2'b00, cyc, a, wd, wr, clash, be_bad, unst);
        total++;
        if (ok !== 1'b1 || cyc !== 1 || wr !== 1'b0 || a !== 8'h08) begin
            bad++; $display("FAIL after_bad_bus: got ok=%b cycles=%0d write=%b addr=%h want 1 1 0 08", ok, cyc, wr, a);
        end
        recv_word(4, word, ok);
        total++;
        if (ok !== 1'b1 || word !== 32'hA5A55A5A) begin
            bad++; $display("FAIL after_bad_reply: got ok=%b data=%h want 1 a5a55a5a", ok, word);
        end
    endtask

    task automatic test_tx_stall();
        bit ok; int cyc; logic [7:0] a, b; logic [31:0] wd, word; logic wr, clash, be_bad, unst;
        send_frame(72'h52_0000000C, 5, ok);
        serve_bus(0, 32'hCAFEF00D, 2'b00, cyc, a, wd, wr, clash, be_bad, unst);
        recv(b, ok);
        total++;
        if (ok !== 1'b1 || b !== 8'hCA) begin
            bad++; $display("FAIL stall_first: got ok=%b byte=%h want 1 ca", ok, b);
        end
        tx_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hFE) begin
                bad++; $display("FAIL stall_hold: got tx_tvalid=%b tx_tdata=%h want 1 fe", tx_tvalid, tx_tdata);
            end
            @(negedge clk);
        end
        recv_word(3, word, ok);
        total++;
        if (ok !== 1'b1 || word !== 32'h00FEF00D || tx_tvalid !== 1'b0) begin
            bad++; $display("FAIL stall_rest: got ok=%b data=%h tx_tvalid=%b want 1 00fef00d 0", ok, word, tx_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; logic [7:0] a, b; logic [31:0] wd, word; logic wr, clash, be_bad, unst;
        send_frame(72'h57_AABBCC99_00000001, 9, ok);
        serve_bus(2, 32'h0, 2'b00, cyc, a, wd, wr, clash, be_bad, unst);
        total++;
        if (ok !== 1'b1 || cyc !== 3 || a !== 8'h99 || wd !== 32'h00000001 || unst !== 1'b0) begin
            bad++; $display("FAIL trunc_wr: got ok=%b cycles=%0d addr=%h data=%h unstable=%b want 1 3 99 00000001 0",
                            ok, cyc, a, wd, unst);
        end
        recv(b, ok);
        send_frame(72'h52_11223344, 5, ok);
        serve_bus(0, 32'h0BADF00D, 2'b00, cyc, a, wd, wr, clash, be_bad, unst);
        total++;
        if (ok !== 1'b1 || b !== 8'h4B || a !== 8'h44 || wr !== 1'b0) begin
            bad++; $display("FAIL b2b_rd: got ok=%b prev_reply=%h addr=%h write=%b want 1 4b 44 0", ok, b, a, wr);
        end
        recv_word(4, word, ok);
        total++;
        if (ok !== 1'b1 || word !== 32'h0BADF00D) begin
            bad++; $display("FAIL b2b_reply: got ok=%b data=%h want 1 0badf00d", ok, word);
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        send_frame(72'h52_00000050, 5, ok);
        avl_waitrequest = 1'b1;
        @(negedge clk);
        total++;
        if (ok !== 1'b1 || avl_read !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL pre_reset_read: got ok=%b avl_read=%b busy=%b want 1 1 1", ok, avl_read, busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({rx_tready, tx_tvalid, tx_tdata, avl_read, avl_write, avl_address, avl_writedata,
             avl_byteenable, busy} !== 57'd0) begin
            bad++; $display("FAIL mid_reset: got rx_rdy=%b rd=%b wr=%b addr=%h be=%h busy=%b want all zero",
                            rx_tready, avl_read, avl_write, avl_address, avl_byteenable, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        avl_waitrequest = 1'b0;
        @(negedge clk);
        total++;
        if (rx_tready !== 1'b1 || avl_read !== 1'b0 || tx_tvalid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset: got rx_rdy=%b rd=%b tx_vld=%b busy=%b want 1 0 0 0",
                            rx_tready, avl_read, tx_tvalid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_err();
        test_bad_cmd();
        test_tx_stall();
        test_back_to_back();
        test_reset_mid_read();
        test_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
